pc_ctrl_ras: RTL

//  Parametrised program-counter unit for the pipelined core: fetch-address register, PC+1 incrementer,

---
 rtl/pc_ctrl_ras.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/pc_ctrl_ras.sv
// pc_ctrl_ras : program-counter unit for the pipelined core.
//   Holds the fetch address, increments it, delays PC+1 through a configurable
//   pipe, keeps a circular hardware return-address stack for call/ret, and
//   handles a single-level interrupt with a saved return PC (epc).
//
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   stall          freeze pc, pipe stage 0, RAS, epc and in_isr
//   flow_change    EX taken branch/jump to flow_tgt
//   call / ret     EX call (push return address) / return (pop RAS top)
//   reti           EX return from interrupt to epc
//   flow_tgt       EX redirect target
//   int_req/int_en level interrupt request / global enable
//   pc             fetch address
//   pc_pipe        PC+1 per pipe stage, stage k at [k*PC_W +: PC_W]
//   epc, in_isr    saved interrupt return PC / handler active
//   int_ack        one-cycle pulse when the interrupt entry takes effect
//   ras_empty/full RAS occupancy flags
//   ras_err        sticky RAS overflow / underflow / call&ret collision
module pc_ctrl_ras #(
  parameter int unsigned     PC_W     = 16,
  parameter logic [PC_W-1:0] RST_VEC  = {PC_W{1'b0}},
  parameter logic [PC_W-1:0] INT_VEC  = PC_W'(16'h0002),
  parameter int unsigned     PIPE_STG = 3,
  parameter int unsigned     RAS_DEP  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall,
  input  logic                     flow_change,
  input  logic                     call,
  input  logic                     ret,
  input  logic                     reti,
  input  logic [PC_W-1:0]          flow_tgt,
  input  logic                     int_req,
  input  logic                     int_en,
  output logic [PC_W-1:0]          pc,
  output logic [PIPE_STG*PC_W-1:0] pc_pipe,
  output logic [PC_W-1:0]          epc,
  output logic                     in_isr,
  output logic                     int_ack,
  output logic                     ras_empty,
  output logic                     ras_full,
  output logic                     ras_err
);

  localparam int RAS_AW = $clog2(RAS_DEP);
  localparam int CNT_W  = RAS_AW + 1;

  logic [PC_W-1:0]   pc_r;
  logic [PC_W-1:0]   pc_nxt_s;
  logic [PC_W-1:0]   pc_inc_s;
  logic [PC_W-1:0]   epc_r;
  logic [PC_W-1:0]   epc_nxt_s;
  logic              in_isr_r;
  logic              in_isr_nxt_s;
  logic              int_ack_r;
  logic              int_ack_nxt_s;
  logic              ras_err_r;
  logic              ras_err_nxt_s;
  logic [PC_W-1:0]   pipe_r [PIPE_STG];
  logic [PC_W-1:0]   ras_mem_r [RAS_DEP];
  logic [RAS_AW-1:0] sp_r;
  logic [RAS_AW-1:0] sp_nxt_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic              push_s;
  logic              pop_s;
  logic              empty_s;
  logic              full_s;
  logic [PC_W-1:0]   ras_top_s;

  assign pc_inc_s  = pc_r + PC_W'(1);
  assign empty_s   = (cnt_r == CNT_W'(0));
  assign full_s    = (cnt_r == CNT_W'(RAS_DEP));
  // sp_r points at the next free slot, so the top lives one below it
  assign ras_top_s = ras_mem_r[sp_r - RAS_AW'(1)];

  // Next-PC selection, interrupt entry/exit and RAS bookkeeping
  always_comb begin
    pc_nxt_s      = pc_r;
    epc_nxt_s     = epc_r;
    in_isr_nxt_s  = in_isr_r;
    int_ack_nxt_s = 1'b0;
    ras_err_nxt_s = ras_err_r;
    push_s        = 1'b0;
    pop_s         = 1'b0;
    if (!stall) begin
      // call and ret together is a collision even though ret wins
      ras_err_nxt_s = ras_err_r | (call & ret);
      if (reti) begin
        pc_nxt_s     = epc_r;
        in_isr_nxt_s = 1'b0;
      end else if (ret) begin
        if (empty_s) begin
          pc_nxt_s      = flow_tgt;
          ras_err_nxt_s = 1'b1;
        end else begin
          pc_nxt_s = ras_top_s;
          pop_s    = 1'b1;
        end
      end else if (call) begin
        pc_nxt_s      = flow_tgt;
        push_s        = 1'b1;
        ras_err_nxt_s = ras_err_r | full_s;
      end else if (flow_change) begin
        pc_nxt_s = flow_tgt;
      end else if (int_req && int_en && !in_isr_r) begin
        epc_nxt_s     = pc_r;
        pc_nxt_s      = INT_VEC;
        in_isr_nxt_s  = 1'b1;
        int_ack_nxt_s = 1'b1;
      end else begin
        pc_nxt_s = pc_inc_s;
      end
    end else begin
      pc_nxt_s = pc_r;
    end
  end

  // RAS pointer and occupancy; a push when full overwrites the oldest slot
  always_comb begin
    sp_nxt_s  = sp_r;
    cnt_nxt_s = cnt_r;
    if (push_s) begin
      sp_nxt_s  = sp_r + RAS_AW'(1);
      cnt_nxt_s = full_s ? cnt_r : (cnt_r + CNT_W'(1));
    end else if (pop_s) begin
      sp_nxt_s  = sp_r - RAS_AW'(1);
      cnt_nxt_s = cnt_r - CNT_W'(1);
    end else begin
      sp_nxt_s  = sp_r;
      cnt_nxt_s = cnt_r;
    end
  end

  // Architectural state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r      <= RST_VEC;
      epc_r     <= {PC_W{1'b0}};
      in_isr_r  <= 1'b0;
      int_ack_r <= 1'b0;
      ras_err_r <= 1'b0;
      sp_r      <= {RAS_AW{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
    end else begin
      pc_r      <= pc_nxt_s;
      epc_r     <= epc_nxt_s;
      in_isr_r  <= in_isr_nxt_s;
      int_ack_r <= int_ack_nxt_s;
      ras_err_r <= ras_err_nxt_s;
      sp_r      <= sp_nxt_s;
      cnt_r     <= cnt_nxt_s;
    end
  end

  // PC+1 delay line: stage 0 obeys stall, later stages always advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < PIPE_STG; k++) begin
        pipe_r[k] <= {PC_W{1'b0}};
      end
    end else begin
      if (!stall) begin
        pipe_r[0] <= pc_inc_s;
      end else begin
        pipe_r[0] <= pipe_r[0];
      end
      for (int k = 1; k < PIPE_STG; k++) begin
        pipe_r[k] <= pipe_r[k-1];
      end
    end
  end

  // RAS storage; contents are don't-care while count is zero
  always_ff @(posedge clk) begin
    if (push_s) begin
      ras_mem_r[sp_r] <= pipe_r[1];
    end else begin
      ras_mem_r[sp_r] <= ras_mem_r[sp_r];
    end
  end

  genvar g;
  generate
    for (g = 0; g < PIPE_STG; g++) begin : g_pipe_out
      assign pc_pipe[g*PC_W +: PC_W] = pipe_r[g];
    end
  endgenerate

  assign pc        = pc_r;
  assign epc       = epc_r;
  assign in_isr    = in_isr_r;
  assign int_ack   = int_ack_r;
  assign ras_empty = empty_s;
  assign ras_full  = full_s;
  assign ras_err   = ras_err_r;

endmodule
